// File: rtl/register_file_nbits.sv
`default_nettype none
// ============================================================================
// Module   : register_file_nbits
// Purpose  : Multi-entry register file, one byte-enabled write port and two
//            independent read ports, optional zero entry / bypass / reg read.
// Revision : 1.0
// ============================================================================
module register_file_nbits #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = $clog2(DEPTH),
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int REG_READ = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [WIDTH-1:0]   wdata,
   input  logic [WIDTH/8-1:0] wbe,
   input  logic               ren,
   input  logic [AW-1:0]      raddr_a,
   input  logic [AW-1:0]      raddr_b,
   output logic [WIDTH-1:0]   rdata_a,
   output logic [WIDTH-1:0]   rdata_b
);
   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] mem [DEPTH];
   logic             waddr_ok;
   logic             write_legal;
   logic [AW-1:0]    widx;
   logic [WIDTH-1:0] wmerged;
   logic [WIDTH-1:0] read_a;
   logic [WIDTH-1:0] read_b;

   // An address is live when it maps to a real entry that is not the zero entry.
   function automatic logic addr_live(input logic [AW-1:0] a);
      return (32'(a) < DEPTH) && !(ZERO_REG != 0 && a == '0);
   endfunction

   always_comb begin
      waddr_ok    = addr_live(waddr);
      write_legal = we && waddr_ok;
      widx        = waddr_ok ? waddr : '0;
      wmerged     = mem[widx];
      for (int i = 0; i < NB; i++) begin
         if (wbe[i]) begin
            wmerged[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (write_legal) begin
         mem[widx] <= wmerged;
      end
   end

   always_comb begin
      read_a = '0;
      if (addr_live(raddr_a)) begin
         read_a = mem[raddr_a];
         if (BYPASS != 0 && write_legal && raddr_a == waddr) begin
            read_a = wmerged;
         end
      end
   end

   always_comb begin
      read_b = '0;
      if (addr_live(raddr_b)) begin
         read_b = mem[raddr_b];
         if (BYPASS != 0 && write_legal && raddr_b == waddr) begin
            read_b = wmerged;
         end
      end
   end

   generate
      if (REG_READ != 0) begin : g_reg_read
         always_ff @(posedge clk) begin
            if (rst) begin
               rdata_a <= '0;
               rdata_b <= '0;
            end else if (ren) begin
               rdata_a <= read_a;
               rdata_b <= read_b;
            end
         end
      end else begin : g_comb_read
         logic unused_ren;
         assign unused_ren = ren;
         assign rdata_a    = read_a;
         assign rdata_b    = read_b;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_register_file_nbits.sv
`default_nettype none
// Testbench for register_file_nbits: four parameter variants driven in
// lockstep from shared inputs and checked against an array-based model.
module tb_register_file_nbits;
   localparam int NI = 4;

   // Variant table: 0 default, 1 shallow/no-zero/no-bypass/registered,
   // 2 registered with zero+bypass, 3 combinational without zero/bypass.
   int c_depth [NI] = '{32, 24, 32, 32};
   bit c_zero  [NI] = '{1, 0, 1, 0};
   bit c_byp   [NI] = '{1, 0, 1, 0};
   bit c_rr    [NI] = '{0, 1, 1, 0};

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [3:0]  wbe;
   logic        ren;
   logic [4:0]  raddr_a;
   logic [4:0]  raddr_b;
   logic [31:0] out_a [NI];
   logic [31:0] out_b [NI];

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] mem_m [NI][32];
   logic [31:0] rq_a  [NI];
   logic [31:0] rq_b  [NI];

   register_file_nbits u0 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .ren(ren), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(out_a[0]), .rdata_b(out_b[0]));

   register_file_nbits #(.DEPTH(24), .ZERO_REG(0), .BYPASS(0), .REG_READ(1)) u1 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .ren(ren), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(out_a[1]), .rdata_b(out_b[1]));

   register_file_nbits #(.REG_READ(1)) u2 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .ren(ren), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(out_a[2]), .rdata_b(out_b[2]));

   register_file_nbits #(.ZERO_REG(0), .BYPASS(0)) u3 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .ren(ren), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .rdata_a(out_a[3]), .rdata_b(out_b[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic bit write_ok(int k);
      return we && (int'(waddr) < c_depth[k]) && !(c_zero[k] && waddr == 0);
   endfunction

   function automatic logic [31:0] merged(int k);
      logic [31:0] v;
      v = mem_m[k][waddr];
      for (int b = 0; b < 4; b++)
         if (wbe[b]) v[8*b +: 8] = wdata[8*b +: 8];
      return v;
   endfunction

   function automatic logic [31:0] read_now(int k, logic [4:0] ra);
      if (int'(ra) >= c_depth[k] || (c_zero[k] && ra == 0)) return 32'h0;
      if (c_byp[k] && write_ok(k) && ra == waddr) return merged(k);
      return mem_m[k][ra];
   endfunction

   function automatic logic [31:0] expect_out(int k, bit port_b);
      if (c_rr[k]) return port_b ? rq_b[k] : rq_a[k];
      return read_now(k, port_b ? raddr_b : raddr_a);
   endfunction

   task automatic model_edge();
      for (int k = 0; k < NI; k++) begin
         if (rst) begin
            for (int a = 0; a < 32; a++) mem_m[k][a] = 32'h0;
            rq_a[k] = 32'h0;
            rq_b[k] = 32'h0;
         end else begin
            if (c_rr[k] && ren) begin
               rq_a[k] = read_now(k, raddr_a);
               rq_b[k] = read_now(k, raddr_b);
            end
            if (write_ok(k)) mem_m[k][waddr] = merged(k);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < NI; k++) begin
         if (c_rr[k]) begin
            compared++;
            if (out_a[k] !== 32'h0 || out_b[k] !== 32'h0) begin
               mismatched++;
               $display("FAIL reset_regout inst%0d: got a=%h b=%h want 0", k, out_a[k], out_b[k]);
            end
         end
      end
      ren = 1'b1;
      for (int a = 0; a < 32; a++) begin
         raddr_a = 5'(a);
         raddr_b = 5'(31 - a);
         tick();
         for (int k = 0; k < NI; k++) begin
            compared++;
            if (out_a[k] !== 32'h0 || out_b[k] !== 32'h0) begin
               mismatched++;
               $display("FAIL reset_read inst%0d addr %0d: got a=%h b=%h want 0", k, a, out_a[k], out_b[k]);
            end
         end
      end
      ren = 1'b0;
   endtask

   task automatic test_partial_write();
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wbe = 4'b1111;
      tick();
      wdata = 32'h11223344; wbe = 4'b0101;
      tick();
      we = 1'b0; raddr_a = 5'd5; raddr_b = 5'd6; ren = 1'b1;
      tick();
      ren = 1'b0;
      for (int k = 0; k < NI; k++) begin
         compared++;
         if (out_a[k] !== 32'hDE22BE44 || out_b[k] !== 32'h0) begin
            mismatched++;
            $display("FAIL partial_write inst%0d: got a=%h b=%h want a=de22be44 b=0", k, out_a[k], out_b[k]);
         end
      end
   endtask

   task automatic test_zero_reg();
      logic [31:0] want [NI];
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wbe = 4'b1111;
      raddr_a = 5'd0; raddr_b = 5'd0; ren = 1'b1;
      #1;
      compared++;
      if (out_a[0] !== 32'h0 || out_b[0] !== 32'h0) begin
         mismatched++;
         $display("FAIL zero_same_cycle inst0: got a=%h b=%h want 0", out_a[0], out_b[0]);
      end
      tick();
      we = 1'b0;
      tick();
      ren = 1'b0;
      want = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
      for (int k = 0; k < NI; k++) begin
         compared++;
         if (out_a[k] !== want[k] || out_b[k] !== want[k]) begin
            mismatched++;
            $display("FAIL zero_reg inst%0d: got a=%h b=%h want %h", k, out_a[k], out_b[k], want[k]);
         end
      end
   endtask

   task automatic test_bypass();
      logic [31:0] want [NI];
      we = 1'b1; waddr = 5'd7; wdata = 32'hAAAAAAAA; wbe = 4'b1111;
      tick();
      wdata = 32'h55555555; wbe = 4'b0011;
      raddr_a = 5'd7; raddr_b = 5'd7; ren = 1'b1;
      #1;
      want = '{32'hAAAA5555, 32'h0, 32'h0, 32'hAAAAAAAA};
      for (int k = 0; k < NI; k++) begin
         if (!c_rr[k]) begin
            compared++;
            if (out_a[k] !== want[k] || out_b[k] !== want[k]) begin
               mismatched++;
               $display("FAIL bypass_same_cycle inst%0d: got a=%h b=%h want %h", k, out_a[k], out_b[k], want[k]);
            end
         end
      end
      tick();
      we = 1'b0;
      want = '{32'hAAAA5555, 32'hAAAAAAAA, 32'hAAAA5555, 32'hAAAA5555};
      for (int k = 0; k < NI; k++) begin
         compared++;
         if (out_a[k] !== want[k] || out_b[k] !== want[k]) begin
            mismatched++;
            $display("FAIL bypass_next inst%0d: got a=%h b=%h want %h", k, out_a[k], out_b[k], want[k]);
         end
      end
      tick();
      ren = 1'b0;
      for (int k = 0; k < NI; k++) begin
         compared++;
         if (out_a[k] !== 32'hAAAA5555 || out_b[k] !== 32'hAAAA5555) begin
            mismatched++;
            $display("FAIL bypass_after inst%0d: got a=%h b=%h want aaaa5555", k, out_a[k], out_b[k]);
         end
      end
   endtask

   task automatic test_reg_hold();
      logic [31:0] want [NI];
      ren = 1'b0;
      we = 1'b1; waddr = 5'd3; wdata = 32'h12345678; wbe = 4'b1111;
      tick();
      waddr = 5'd4; wdata = 32'h9ABCDEF0;
      tick();
      we = 1'b0; ren = 1'b1; raddr_a = 5'd3;
      tick();
      ren = 1'b0; raddr_a = 5'd4;
      for (int s = 0; s < 2; s++) begin
         if (s == 1) tick();
         for (int k = 0; k < NI; k++) begin
            if (c_rr[k]) begin
               compared++;
               if (out_a[k] !== 32'h12345678) begin
                  mismatched++;
                  $display("FAIL reg_hold step%0d inst%0d: got %h want 12345678", s, k, out_a[k]);
               end
            end
         end
      end
      ren = 1'b1;
      tick();
      ren = 1'b0;
      want = '{32'h9ABCDEF0, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h9ABCDEF0};
      for (int k = 0; k < NI; k++) begin
         compared++;
         if (out_a[k] !== want[k]) begin
            mismatched++;
            $display("FAIL reg_reload inst%0d: got %h want %h", k, out_a[k], want[k]);
         end
      end
   endtask

   task automatic test_reset_mid_and_range();
      rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D; wbe = 4'b1111;
      tick();
      rst = 1'b0; we = 1'b0; raddr_a = 5'd9; ren = 1'b1;
      tick();
      for (int k = 0; k < NI; k++) begin
         compared++;
         if (out_a[k] !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_discard inst%0d: got %h want 0", k, out_a[k]);
         end
      end
      we = 1'b1; waddr = 5'd6; wdata = 32'h0BADC0DE;
      tick();
      waddr = 5'd30; wdata = 32'h12345678; raddr_a = 5'd30; raddr_b = 5'd6;
      tick();
      we = 1'b0;
      tick();
      compared++;
      if (out_a[1] !== 32'h0 || out_b[1] !== 32'h0BADC0DE) begin
         mismatched++;
         $display("FAIL out_of_range inst1: got a=%h b=%h want a=0 b=0badc0de", out_a[1], out_b[1]);
      end
      compared++;
      if (out_a[0] !== 32'h12345678) begin
         mismatched++;
         $display("FAIL in_range_30 inst0: got %h want 12345678", out_a[0]);
      end
      for (int a = 0; a < 32; a++) begin
         raddr_a = 5'(a);
         raddr_b = 5'(a ^ 1);
         tick();
         for (int k = 0; k < NI; k++) begin
            compared++;
            if (out_a[k] !== expect_out(k, 1'b0) || out_b[k] !== expect_out(k, 1'b1)) begin
               mismatched++;
               $display("FAIL range_sweep inst%0d addr %0d: got a=%h b=%h want a=%h b=%h",
                        k, a, out_a[k], out_b[k], expect_out(k, 1'b0), expect_out(k, 1'b1));
            end
         end
      end
      ren = 1'b0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst     = ($urandom_range(0, 39) == 0);
         we      = ($urandom_range(0, 3) != 0);
         waddr   = 5'($urandom_range(0, 31));
         wdata   = $urandom;
         wbe     = 4'($urandom_range(0, 15));
         ren     = ($urandom_range(0, 3) != 0);
         raddr_a = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
         raddr_b = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
         #1;
         for (int k = 0; k < NI; k++) begin
            compared++;
            if (out_a[k] !== expect_out(k, 1'b0) || out_b[k] !== expect_out(k, 1'b1)) begin
               mismatched++;
               $display("FAIL random cycle%0d inst%0d: got a=%h b=%h want a=%h b=%h",
                        n, k, out_a[k], out_b[k], expect_out(k, 1'b0), expect_out(k, 1'b1));
            end
         end
         tick();
      end
      rst = 1'b0; we = 1'b0; ren = 1'b0;
   endtask

   initial begin
      rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wbe = '0;
      ren = 1'b0; raddr_a = '0; raddr_b = '0;
      for (int k = 0; k < NI; k++) begin
         rq_a[k] = 32'h0;
         rq_b[k] = 32'h0;
         for (int a = 0; a < 32; a++) mem_m[k][a] = 32'h0;
      end
      test_reset();
      test_partial_write();
      test_zero_reg();
      test_bypass();
      test_reg_hold();
      test_reset_mid_and_range();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/register_file_nbits.md
Name: register_file_nbits

Overview:
- Parametrised multi-entry register file, successor to the single enabled N-bit register used throughout the multi-cycle datapath.
- One write port with byte enables and two read ports (A, B).
- Optional hardwired-zero entry 0, optional write-to-read bypass, and a selectable combinational or registered read mode.
- Serves as the architectural register file feeding the A/B operand registers.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of entries; need not be a power of two.
- AW, $clog2(DEPTH), address width.
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to that read port.
- REG_READ, 0, 0 = combinational read; 1 = read data registered, one-cycle latency, qualified by ren.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- we  input  1  write enable
- waddr  input  AW  write address
- wdata  input  WIDTH  write data
- wbe  input  WIDTH/8  byte enables; bit i qualifies wdata[8i+7:8i]
- ren  input  1  read enable; used only when REG_READ=1, ignored otherwise
- raddr_a  input  AW  read address, port A
- raddr_b  input  AW  read address, port B
- rdata_a  output  WIDTH  read data, port A
- rdata_b  output  WIDTH  read data, port B

Behaviour:
Reset:
- rst=1 at a rising edge clears every entry to 0.
- When REG_READ=1, rdata_a and rdata_b also clear to 0.
- rst has priority: we and ren are ignored in a reset cycle.
- Reset asserted mid-sequence discards that cycle's write.

Write:
- At a rising edge with we=1 and rst=0, entry[waddr] byte i takes wdata byte i for every wbe[i]=1; other bytes hold.
- wbe all-zero leaves the entry unchanged.
- Writes are ignored when waddr>=DEPTH.
- Writes are ignored when ZERO_REG=1 and waddr=0.

Read value (computed per port):
- Read value = entry[raddr].
- Forced to 0 if raddr>=DEPTH or (ZERO_REG=1 and raddr=0).
- If BYPASS=1, we=1, raddr=waddr and the write is legal (in range, not the zero entry), the read value is the byte-merged result: wdata bytes where wbe=1, stored bytes elsewhere.
- If BYPASS=0, the read value is the pre-write contents.
- Ports A and B are independent; both may address the same entry, and both bypass.

REG_READ=0:
- rdata_x is the combinational read value; zero latency.
- Post-write value is visible after the edge, or within the same cycle when bypassed.

REG_READ=1:
- At a rising edge with ren=1, rdata_x captures the read value, so latency is one cycle.
- ren=0 holds rdata_x.
- Bypass applies to the captured value.

Other rules:
- No internal state machine beyond storage.
- The only simultaneous event is the same-address read/write, resolved as above.

Test Plan:
1. Reset then read: rst=1 for 2 cycles, then read all addresses 0..31 on both ports -> all read 0; with REG_READ=1, rdata_a/b=0 immediately after reset.
2. Full and partial write: write 0xDEADBEEF to addr 5 with wbe=4'b1111, then write 0x11223344 to addr 5 with wbe=4'b0101 -> raddr_a=5 reads 0xDE22BE44; raddr_b=6 reads 0.
3. Zero register: ZERO_REG=1, write 0xFFFFFFFF to addr 0 -> reads 0, including in the same cycle with BYPASS=1. ZERO_REG=0, same write -> reads 0xFFFFFFFF.
4. Bypass: addr 7 holds 0xAAAAAAAA; in one cycle write 0x55555555 to addr 7 (wbe=4'b0011) with raddr_a=raddr_b=7.
   - BYPASS=1: both ports read 0xAAAA5555 in that cycle (REG_READ=0), or on the next edge (REG_READ=1).
   - BYPASS=0: 0xAAAAAAAA that cycle, then 0xAAAA5555 afterwards.
5. Registered read hold: REG_READ=1, addr 3=0x12345678, addr 4=0x9ABCDEF0.
   - ren=1 with raddr_a=3 -> rdata_a=0x12345678 after one edge.
   - Then ren=0 with raddr_a=4 -> rdata_a stays 0x12345678.
   - Then ren=1 -> 0x9ABCDEF0.
6. Reset mid-operation and range check:
   - rst=1 coincident with we=1 writing 0xCAFEF00D to addr 9 -> addr 9 reads 0 after reset.
   - DEPTH=24: write to addr 30 -> no entry changes; raddr=30 reads 0.
